// File: rtl/atm_session_timer_if.sv
// Control/status bundle between the ATM controller and the session inactivity timer.
// The controller drives the session pulses; the timer returns its registered status.
interface atm_session_timer_if #(
    parameter int unsigned CNT_W = 8
) ();

    logic             start;
    logic             activity;
    logic             done;
    logic             active;
    logic             warn;
    logic             timeout;
    logic             locked;
    logic [CNT_W-1:0] secs_left;

    modport master (
        output start,
        output activity,
        output done,
        input  active,
        input  warn,
        input  timeout,
        input  locked,
        input  secs_left
    );

    modport slave (
        input  start,
        input  activity,
        input  done,
        output active,
        output warn,
        output timeout,
        output locked,
        output secs_left
    );

endinterface

// File: rtl/atm_session_timer.sv
// Customer-session inactivity timer: samples the slow sec_clk, turns each rise into a tick,
// counts down from TIMEOUT_S, warns near expiry and locks the session at zero.
module atm_session_timer #(
    parameter int unsigned TIMEOUT_S = 30,
    parameter int unsigned WARN_S    = 10,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sec_clk,
    atm_session_timer_if.slave   bus
);

    localparam logic [CNT_W-1:0] Reload  = CNT_W'(TIMEOUT_S);
    localparam logic [CNT_W-1:0] WarnLvl = CNT_W'(WARN_S);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntZero = '0;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StWarn,
        StExpired
    } state_e;

    // sec_clk is asynchronous: two flops for metastability, a third for edge detection.
    logic [1:0] sync_q;
    logic       prev_q;
    logic       tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], sec_clk};
            prev_q <= sync_q[1];
        end
    end

    assign tick = sync_q[1] & ~prev_q;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             active_q, active_d;
    logic             warn_q, warn_d;
    logic             locked_q, locked_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                    cnt_d   = Reload;
                end
            end

            StRun, StWarn: begin
                if (bus.done) begin
                    state_d = StIdle;
                    cnt_d   = CntZero;
                end else if (bus.start || bus.activity) begin
                    // Reload takes priority; a coincident tick is dropped.
                    state_d = StRun;
                    cnt_d   = Reload;
                end else if (tick) begin
                    if (cnt_q > CntOne) begin
                        cnt_d   = cnt_q - CntOne;
                        state_d = (cnt_d <= WarnLvl) ? StWarn : StRun;
                    end else begin
                        state_d   = StExpired;
                        cnt_d     = CntZero;
                        timeout_d = 1'b1;
                    end
                end
            end

            StExpired: begin
                cnt_d = CntZero;
                if (bus.done) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
                cnt_d   = CntZero;
            end
        endcase

        // Status flags are decoded from the next state so they land with secs_left.
        active_d = (state_d == StRun) || (state_d == StWarn);
        warn_d   = (state_d == StWarn);
        locked_d = (state_d == StExpired);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= CntZero;
            timeout_q <= 1'b0;
            active_q  <= 1'b0;
            warn_q    <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            active_q  <= active_d;
            warn_q    <= warn_d;
            locked_q  <= locked_d;
        end
    end

    assign bus.secs_left = cnt_q;
    assign bus.timeout   = timeout_q;
    assign bus.active    = active_q;
    assign bus.warn      = warn_q;
    assign bus.locked    = locked_q;

endmodule

// File: tb/tb_atm_session_timer.sv
// Bench for atm_session_timer: two instances (5/2 and 1/0) checked every cycle against a
// session-level reference model, with directed scenarios followed by random pulses.
module tb_atm_session_timer;

    localparam int unsigned CW = 8;

    logic clk;
    logic rst;
    logic sec_clk;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    atm_session_timer_if #(.CNT_W(CW)) bus0 ();
    atm_session_timer_if #(.CNT_W(CW)) bus1 ();

    logic st [2];
    logic ac [2];
    logic dn [2];

    assign bus0.start    = st[0];
    assign bus0.activity = ac[0];
    assign bus0.done     = dn[0];
    assign bus1.start    = st[1];
    assign bus1.activity = ac[1];
    assign bus1.done     = dn[1];

    logic          o_act  [2];
    logic          o_warn [2];
    logic          o_to   [2];
    logic          o_lock [2];
    logic [CW-1:0] o_left [2];

    assign o_act[0]  = bus0.active;
    assign o_warn[0] = bus0.warn;
    assign o_to[0]   = bus0.timeout;
    assign o_lock[0] = bus0.locked;
    assign o_left[0] = bus0.secs_left;
    assign o_act[1]  = bus1.active;
    assign o_warn[1] = bus1.warn;
    assign o_to[1]   = bus1.timeout;
    assign o_lock[1] = bus1.locked;
    assign o_left[1] = bus1.secs_left;

    atm_session_timer #(.TIMEOUT_S(5), .WARN_S(2), .CNT_W(CW)) u_dut0 (
        .clk     (clk),
        .rst     (rst),
        .sec_clk (sec_clk),
        .bus     (bus0)
    );

    atm_session_timer #(.TIMEOUT_S(1), .WARN_S(0), .CNT_W(CW)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .sec_clk (sec_clk),
        .bus     (bus1)
    );

    // Session model: running/locked flags plus remaining ticks; warn follows from the count.
    int tmo [2];
    int wrn [2];
    bit m_run  [2];
    bit m_lock [2];
    bit m_to   [2];
    int m_left [2];

    int rise_q [$];
    int edge_no;
    int sec_phase;
    int n_tests;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_active", d), 32'(o_act[d]), 32'(m_run[d]));
            check($sformatf("d%0d_warn", d), 32'(o_warn[d]),
                  32'(m_run[d] && (m_left[d] <= wrn[d])));
            check($sformatf("d%0d_timeout", d), 32'(o_to[d]), 32'(m_to[d]));
            check($sformatf("d%0d_locked", d), 32'(o_lock[d]), 32'(m_lock[d]));
            check($sformatf("d%0d_secs_left", d), 32'(o_left[d]), m_left[d]);
        end
    endtask

    task automatic model_step(input int d, input bit s, input bit a, input bit q, input bit t);
        m_to[d] = 1'b0;
        if (m_run[d]) begin
            if (q) begin
                m_run[d]  = 1'b0;
                m_left[d] = 0;
            end else if (s || a) begin
                m_left[d] = tmo[d];
            end else if (t) begin
                if (m_left[d] > 1) begin
                    m_left[d] = m_left[d] - 1;
                end else begin
                    m_run[d]  = 1'b0;
                    m_lock[d] = 1'b1;
                    m_left[d] = 0;
                    m_to[d]   = 1'b1;
                end
            end
        end else if (m_lock[d]) begin
            if (q) m_lock[d] = 1'b0;
        end else if (s) begin
            m_run[d]  = 1'b1;
            m_left[d] = tmo[d];
        end
    endtask

    function automatic bit tick_next();
        return (rise_q.size() > 0) && (rise_q[0] + 3 == edge_no + 1);
    endfunction

    // One clk cycle: model consumes the inputs held across the edge, then outputs are checked.
    task automatic cycle();
        bit t;
        bit nv;
        @(posedge clk);
        edge_no++;
        t = (rise_q.size() > 0) && (rise_q[0] + 3 == edge_no);
        if (t) void'(rise_q.pop_front());
        for (int d = 0; d < 2; d++) model_step(d, st[d], ac[d], dn[d], t);
        #1;
        check_outputs();
        for (int d = 0; d < 2; d++) begin
            st[d] = 1'b0;
            ac[d] = 1'b0;
            dn[d] = 1'b0;
        end
        sec_phase++;
        nv = ((sec_phase % 20) >= 10);
        if (nv && !sec_clk) rise_q.push_back(edge_no);
        sec_clk = nv;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_async_d%0d_active", d), 32'(o_act[d]), 0);
            check($sformatf("rst_async_d%0d_warn", d), 32'(o_warn[d]), 0);
            check($sformatf("rst_async_d%0d_locked", d), 32'(o_lock[d]), 0);
            check($sformatf("rst_async_d%0d_secs_left", d), 32'(o_left[d]), 0);
            m_run[d]  = 1'b0;
            m_lock[d] = 1'b0;
            m_to[d]   = 1'b0;
            m_left[d] = 0;
            st[d] = 1'b0;
            ac[d] = 1'b0;
            dn[d] = 1'b0;
        end
        rise_q.delete();
        sec_phase = 0;
        sec_clk   = 1'b0;
        @(posedge clk);
        edge_no++;
        @(posedge clk);
        edge_no++;
        #1;
        rst = 1'b0;
        check_outputs();
    endtask

    initial begin
        bit reached;
        int to_cnt0;
        int to_cnt1;
        int warn_seen1;

        tmo[0] = 5;
        wrn[0] = 2;
        tmo[1] = 1;
        wrn[1] = 0;
        n_tests   = 0;
        n_fail    = 0;
        edge_no   = 0;
        sec_phase = 0;
        sec_clk   = 1'b0;
        rst       = 1'b1;
        for (int d = 0; d < 2; d++) begin
            st[d] = 1'b0;
            ac[d] = 1'b0;
            dn[d] = 1'b0;
            m_run[d]  = 1'b0;
            m_lock[d] = 1'b0;
            m_to[d]   = 1'b0;
            m_left[d] = 0;
        end

        // Power-on reset state.
        repeat (2) begin
            @(posedge clk);
            edge_no++;
        end
        #1;
        check_outputs();
        rst = 1'b0;

        // Ticks and activity/done pulses with no session are ignored.
        for (int i = 0; i < 220; i++) begin
            ac[0] = (i % 13 == 0);
            ac[1] = (i % 17 == 0);
            dn[0] = (i % 29 == 0);
            cycle();
        end
        check("idle_left0", 32'(o_left[0]), 0);

        // Start together with done in idle: start wins.
        st[0] = 1'b1;
        dn[0] = 1'b1;
        cycle();
        check("idle_start_done_active", 32'(o_act[0]), 1);
        check("idle_start_done_left", 32'(o_left[0]), 5);
        dn[0] = 1'b1;
        cycle();

        // Full countdown to expiry on both instances.
        st[0] = 1'b1;
        st[1] = 1'b1;
        cycle();
        to_cnt0 = 0;
        to_cnt1 = 0;
        warn_seen1 = 0;
        for (int i = 0; i < 130; i++) begin
            cycle();
            if (o_to[0] === 1'b1) to_cnt0++;
            if (o_to[1] === 1'b1) to_cnt1++;
            if (o_warn[1] === 1'b1) warn_seen1++;
        end
        check("countdown_to_pulses_d0", to_cnt0, 1);
        check("countdown_to_pulses_d1", to_cnt1, 1);
        check("edge_warn_never", warn_seen1, 0);
        check("countdown_locked_d0", 32'(o_lock[0]), 1);

        // Expired session ignores start/activity/ticks until done.
        for (int i = 0; i < 60; i++) begin
            st[0] = (i % 7 == 0);
            ac[0] = (i % 5 == 0);
            cycle();
        end
        check("expired_locked", 32'(o_lock[0]), 1);
        check("expired_left", 32'(o_left[0]), 0);
        dn[0] = 1'b1;
        dn[1] = 1'b1;
        cycle();
        check("expired_done_locked", 32'(o_lock[0]), 0);
        check("expired_done_active", 32'(o_act[0]), 0);

        // Activity in WARN reloads and clears warn.
        st[0] = 1'b1;
        cycle();
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            if (m_run[0] && m_left[0] == 2) reached = 1'b1;
            else cycle();
        end
        check("wait_warn", 32'(reached), 1);
        check("warn_at_2", 32'(o_warn[0]), 1);
        ac[0] = 1'b1;
        cycle();
        check("reload_warn_left", 32'(o_left[0]), 5);
        check("reload_warn_warn", 32'(o_warn[0]), 0);
        check("reload_warn_active", 32'(o_act[0]), 1);

        // Activity coincident with a tick: reload wins.
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            if (m_run[0] && m_left[0] < 5 && tick_next()) reached = 1'b1;
            else cycle();
        end
        check("wait_tick_align", 32'(reached), 1);
        ac[0] = 1'b1;
        cycle();
        check("reload_tick_left", 32'(o_left[0]), 5);

        // Done beats activity in RUN.
        ac[0] = 1'b1;
        dn[0] = 1'b1;
        cycle();
        check("done_prio_left", 32'(o_left[0]), 0);
        check("done_prio_active", 32'(o_act[0]), 0);

        // Reset mid-session at secs_left 3.
        st[0] = 1'b1;
        cycle();
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            if (m_run[0] && m_left[0] == 3) reached = 1'b1;
            else cycle();
        end
        check("wait_left3", 32'(reached), 1);
        check("pre_rst_left", 32'(o_left[0]), 3);
        do_reset();
        repeat (40) cycle();

        // Random pulses, including multi-cycle and simultaneous ones.
        for (int i = 0; i < 2500; i++) begin
            for (int d = 0; d < 2; d++) begin
                st[d] = ($urandom_range(0, 39) == 0);
                ac[d] = ($urandom_range(0, 29) == 0);
                dn[d] = ($urandom_range(0, 99) == 0);
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
